// File: rtl/fetch_decode.sv
// Fetch/decode controller for the reduced RISC-V core: PC, variable-latency fetch, ADDI/BNE decode.
// Optional TRAP_ILLEGAL_EN: an illegal instruction sets the sticky illegal flag and parks the FSM in HALT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | strobe imem_req for one cycle with imem_addr = pc
// S_WAIT  | hold the address, load ir when imem_valid arrives
// S_EXEC  | one cycle: decode ir, write back, pick the next pc
// S_HALT  | trapped on an illegal instruction, only rst leaves
module fetch_decode #(
   parameter int unsigned        A_WIDTH  = 32,
   parameter int unsigned        D_WIDTH  = 32,
   parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [A_WIDTH-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               imem_valid,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic               ALUsrc,
   output logic               ALUctrl,
   output logic [D_WIDTH-1:0] ImmOp,
   output logic               RegWrite,
   input  logic               EQ,
   output logic [A_WIDTH-1:0] pc,
   output logic               instr_retired,
   output logic               illegal
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef TRAP_ILLEGAL_EN
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC} state_t;
`endif

   state_t               state_q, state_d;
   logic [A_WIDTH-1:0]   pc_q, pc_d;
   logic [31:0]          ir_q, ir_d;
   logic                 is_addi, is_bne;
   logic [A_WIDTH-1:0]   br_off;
`ifdef TRAP_ILLEGAL_EN
   logic                 illegal_q, illegal_d;
`endif

   always_comb begin
      is_addi = (ir_q[6:0] == 7'b0010011) && (ir_q[14:12] == 3'b000);
      is_bne  = (ir_q[6:0] == 7'b1100011) && (ir_q[14:12] == 3'b001);
      br_off  = {{(A_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   end

   // Register fields are passed through raw regardless of instruction type.
   always_comb begin
      rs1     = ir_q[19:15];
      rs2     = ir_q[24:20];
      rd      = ir_q[11:7];
      ALUsrc  = 1'b0;
      ALUctrl = 1'b0;
      ImmOp   = '0;
      if (is_addi) begin
         ALUsrc = 1'b1;
         ImmOp  = {{(D_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
      end else if (is_bne) begin
         ALUctrl = 1'b1;
         ImmOp   = {{(D_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
`ifdef TRAP_ILLEGAL_EN
      illegal_d = illegal_q;
`endif
      unique case (state_q)
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (imem_valid) begin
               ir_d    = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (is_bne && !EQ) pc_d = pc_q + br_off;
            else               pc_d = pc_q + A_WIDTH'(4);
`ifdef TRAP_ILLEGAL_EN
            if (!is_addi && !is_bne) begin
               illegal_d = 1'b1;
               pc_d      = pc_q;
               state_d   = S_HALT;
            end
`endif
         end
`ifdef TRAP_ILLEGAL_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= NOP_INSTR;
`ifdef TRAP_ILLEGAL_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
`ifdef TRAP_ILLEGAL_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Strobes are gated by rst so a reset landing mid-EXEC never leaks a write or retire.
   always_comb begin
      imem_req      = (state_q == S_FETCH) && !rst;
      imem_addr     = pc_q;
      pc            = pc_q;
      RegWrite      = (state_q == S_EXEC) && is_addi && (ir_q[11:7] != 5'd0) && !rst;
`ifdef TRAP_ILLEGAL_EN
      instr_retired = (state_q == S_EXEC) && (is_addi || is_bne) && !rst;
      illegal       = illegal_q;
`else
      instr_retired = (state_q == S_EXEC) && !rst;
      illegal       = 1'b0;
`endif
   end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: hand-computed decode, PC update, handshake and reset vectors.
// Build with +define+TRAP_ILLEGAL_EN to exercise the trapping variant of the illegal-instruction case.
module tb_fetch_decode;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [4:0]  rs1, rs2, rd;
   logic        ALUsrc, ALUctrl;
   logic [31:0] ImmOp;
   logic        RegWrite;
   logic        EQ;
   logic [31:0] pc;
   logic        instr_retired;
   logic        illegal;

   int          n_run  = 0;
   int          n_fail = 0;
   logic [31:0] cur_pc   = 32'h0;
   logic [31:0] last_imm = 32'h0;

   localparam logic [31:0] JUNK = 32'h1230_0093;   // addi x1,x0,0x123: distinct ImmOp if wrongly latched

   fetch_decode #(.A_WIDTH(32), .D_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .rs1(rs1), .rs2(rs2), .rd(rd), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmOp(ImmOp),
      .RegWrite(RegWrite), .EQ(EQ), .pc(pc), .instr_retired(instr_retired), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered one step after the edge that put the DUT in FETCH; leaves it in the next FETCH.
   task automatic exec_instr(input logic [31:0] instr, input int dly, input logic eq_v, input logic spur,
                             input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                             input logic e_src, input logic e_ctl, input logic [31:0] e_imm,
                             input logic e_rw, input logic [31:0] e_npc);
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, cur_pc);
      chk("fetch_rw", RegWrite, 0);
      if (spur) begin
         imem_valid = 1'b1;
         imem_rdata = JUNK;
      end
      tick();
      imem_valid = 1'b0;
      chk("wait_req", imem_req, 0);
      chk("wait_imm_hold", ImmOp, last_imm);
      for (int i = 0; i < dly; i++) begin
         tick();
         chk("wait_addr", imem_addr, cur_pc);
         chk("wait_ret", instr_retired, 0);
         chk("wait_rw", RegWrite, 0);
      end
      imem_valid = 1'b1;
      imem_rdata = instr;
      EQ         = eq_v;
      tick();
      if (spur) imem_rdata = JUNK;
      else      imem_valid = 1'b0;
      chk("exec_rs1", rs1, e_rs1);
      chk("exec_rs2", rs2, e_rs2);
      chk("exec_rd", rd, e_rd);
      chk("exec_alusrc", ALUsrc, e_src);
      chk("exec_aluctrl", ALUctrl, e_ctl);
      chk("exec_imm", ImmOp, e_imm);
      chk("exec_rw", RegWrite, e_rw);
      chk("exec_ret", instr_retired, 1);
      chk("exec_pc", pc, cur_pc);
      chk("exec_req", imem_req, 0);
      tick();
      imem_valid = 1'b0;
      EQ         = 1'b0;
      chk("next_pc", pc, e_npc);
      chk("next_req", imem_req, 1);
      chk("next_imm_hold", ImmOp, e_imm);
      chk("next_illegal", illegal, 0);
      cur_pc   = e_npc;
      last_imm = e_imm;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
      EQ         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_ret", instr_retired, 0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_alusrc", ALUsrc, 1);
      chk("rst_rd", rd, 0);
      chk("rst_imm", ImmOp, 0);
      chk("rst_illegal", illegal, 0);
      rst = 1'b0;
      #1;

      // ADDI x10,x0,255 with single-cycle memory
      exec_instr(32'h0FF00513, 0, 1'b0, 1'b0, 5'd0, 5'd31, 5'd10, 1'b1, 1'b0, 32'h0000_00FF, 1'b1, 32'h4);
      // NOP (rd=0), 4-cycle latency, spurious valids in FETCH and EXEC
      exec_instr(32'h0000_0013, 4, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8);
      // ADDI x1,x2,-1
      exec_instr(32'hFFF10093, 1, 1'b0, 1'b0, 5'd2, 5'd31, 5'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'hC);
      // BNE x11,x0,-8 not taken (EQ=1) at 0xC
      exec_instr(32'hFE059CE3, 0, 1'b1, 1'b0, 5'd11, 5'd0, 5'd25, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h14 - 32'h4);
      // same BNE at 0x10 taken (EQ=0)
      exec_instr(32'hFE059CE3, 2, 1'b0, 1'b1, 5'd11, 5'd0, 5'd25, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h8);
      // BNE -16 taken at 0x8 wraps below zero
      exec_instr(32'hFE0598E3, 0, 1'b0, 1'b0, 5'd11, 5'd0, 5'd17, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'hFFFF_FFF8);
      exec_instr(32'h0000_0013, 0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC);
      // non-branch at the top of the address space wraps to 0
      exec_instr(32'h0FF00513, 1, 1'b1, 1'b0, 5'd0, 5'd31, 5'd10, 1'b1, 1'b0, 32'h0000_00FF, 1'b1, 32'h0);

`ifdef TRAP_ILLEGAL_EN
      chk("ill_fetch_req", imem_req, 1);
      tick();
      imem_valid = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      imem_valid = 1'b0;
      chk("ill_exec_ret", instr_retired, 0);
      chk("ill_exec_rw", RegWrite, 0);
      chk("ill_exec_alusrc", ALUsrc, 0);
      chk("ill_exec_imm", ImmOp, 0);
      tick();
      chk("ill_flag", illegal, 1);
      chk("ill_pc", pc, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("halt_req", imem_req, 0);
         chk("halt_pc", pc, 32'h0);
         chk("halt_ret", instr_retired, 0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("halt_rst_illegal", illegal, 0);
      chk("halt_rst_req", imem_req, 1);
      cur_pc   = 32'h0;
      last_imm = 32'h0;
`else
      // illegal encoding behaves as a NOP
      exec_instr(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4);
`endif

      // reset while in WAIT with a coincident valid
      chk("rw_fetch_req", imem_req, 1);
      tick();
      rst        = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = 32'h0FF00513;
      tick();
      chk("rw_rst_req", imem_req, 0);
      chk("rw_rst_pc", pc, 32'h0);
      chk("rw_rst_rd", rd, 0);
      chk("rw_rst_rw", RegWrite, 0);
      chk("rw_rst_alusrc", ALUsrc, 1);
      rst        = 1'b0;
      imem_valid = 1'b0;
      #1;
      chk("rw_after_req", imem_req, 1);
      chk("rw_after_ret", instr_retired, 0);
      cur_pc   = 32'h0;
      last_imm = 32'h0;
      exec_instr(32'h0FF00513, 0, 1'b0, 1'b0, 5'd0, 5'd31, 5'd10, 1'b1, 1'b0, 32'h0000_00FF, 1'b1, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
